// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment display scheduler.
// Digit enables are active-low; nibbles are hex values for the segment encoder.
package display_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam int DIGITS    = 8;
    localparam int NIBBLE_W  = 4;
    localparam int IDX_W     = $clog2(DIGITS);
    localparam logic [DIGITS-1:0] DIGIT_OFF = 8'hFF;

    function automatic logic [DIGITS-1:0] digit_enable(input logic [IDX_W-1:0] idx);
        logic [DIGITS-1:0] w_one;
        w_one = DIGITS'(1) << idx;
        return ~w_one;
    endfunction

    function automatic logic [NIBBLE_W-1:0] nibble_of(input logic [DIGITS*NIBBLE_W-1:0] word,
                                                      input logic [IDX_W-1:0]           idx);
        return word[{idx, 2'b00} +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell/blank counter for one digit slot. The owner clears it on every state change;
// the strobes are raw compares that the owner qualifies with its own state.
module scan_timer #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 4,
    localparam int CNT_W       = $clog2(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic             show_end,
    output logic             blank_end
);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt       = r_cnt;
    assign show_end  = (r_cnt == SHOW_LAST);
    assign blank_end = (r_cnt == BLANK_LAST);

endmodule

// File: rtl/display_scheduler.sv
// Frame sequencer for the 8-digit display: snapshots one source word per frame,
// then scans digits with a dwell and a blanking gap. All outputs are registered.
module display_scheduler
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic [31:0]          src_cpu,
    input  logic [31:0]          src_sw,
    input  logic                 use_sw,
    input  logic                 hold,
    output logic [DIGITS-1:0]    digital_sel,
    output logic [NIBBLE_W-1:0]  nibble,
    output logic [IDX_W-1:0]     digit_idx,
    output logic                 frame_done,
    output state_t               dbg_state
);

    localparam int CNT_W     = $clog2(SCAN_DIV);
    localparam int BLANK_PRE = (BLANK_CYCLES >= 2) ? BLANK_CYCLES - 2 : 0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t               r_state;
    logic [31:0]          r_snap;
    logic [IDX_W-1:0]     r_idx;
    logic [DIGITS-1:0]    r_sel;
    logic [NIBBLE_W-1:0]  r_nibble;
    logic                 r_done;

    logic [CNT_W-1:0]     w_cnt;
    logic                 w_show_end;
    logic                 w_blank_end;
    logic                 w_clear;
    logic [31:0]          w_snap_next;
    logic [IDX_W-1:0]     w_idx_next;

    scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .nReset    (nReset),
        .clear     (w_clear),
        .cnt       (w_cnt),
        .show_end  (w_show_end),
        .blank_end (w_blank_end)
    );

    // The counter restarts on every state transition, so cnt is slot-relative.
    always_comb begin
        w_clear = 1'b1;
        case (r_state)
            LOAD:    w_clear = 1'b1;
            SHOW:    w_clear = w_show_end;
            BLANK:   w_clear = w_blank_end;
            default: w_clear = 1'b1;
        endcase
    end

    assign w_snap_next = hold ? r_snap : (use_sw ? src_sw : src_cpu);
    assign w_idx_next  = r_idx + IDX_W'(1);

    // Output registers are loaded with the values for the state being entered,
    // so they line up with r_state without any combinational path from inputs.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state  <= LOAD;
            r_snap   <= '0;
            r_idx    <= '0;
            r_sel    <= DIGIT_OFF;
            r_nibble <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                LOAD: begin
                    r_snap   <= w_snap_next;
                    r_idx    <= '0;
                    r_sel    <= digit_enable('0);
                    r_nibble <= nibble_of(w_snap_next, '0);
                    r_state  <= SHOW;
                end
                SHOW: begin
                    if (w_show_end) begin
                        r_sel   <= DIGIT_OFF;
                        r_done  <= (r_idx == LAST_IDX) && (BLANK_CYCLES == 1);
                        r_state <= BLANK;
                    end
                end
                BLANK: begin
                    if (w_blank_end) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= LOAD;
                        end else begin
                            r_idx    <= w_idx_next;
                            r_sel    <= digit_enable(w_idx_next);
                            r_nibble <= nibble_of(r_snap, w_idx_next);
                            r_state  <= SHOW;
                        end
                    end else begin
                        r_done <= (r_idx == LAST_IDX) && (w_cnt == CNT_W'(BLANK_PRE));
                    end
                end
                default: begin
                    r_sel   <= DIGIT_OFF;
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign digital_sel = r_sel;
    assign nibble      = r_nibble;
    assign digit_idx   = r_idx;
    assign frame_done  = r_done;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with SCAN_DIV=8, BLANK_CYCLES=2 (65-cycle frames).
module tb_display_scheduler;
  import display_pkg::*;

  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int SHOW_CYC     = SCAN_DIV - BLANK_CYCLES;
  localparam int FRAME_CYC    = 8 * SCAN_DIV + 1;

  logic        clk;
  logic        nReset;
  logic [31:0] src_cpu;
  logic [31:0] src_sw;
  logic        use_sw;
  logic        hold;
  logic [7:0]  digital_sel;
  logic [3:0]  nibble;
  logic [2:0]  digit_idx;
  logic        frame_done;
  state_t      dbg_state;

  int n_vec;
  int n_err;

  display_scheduler #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk         (clk),
    .nReset      (nReset),
    .src_cpu     (src_cpu),
    .src_sw      (src_sw),
    .use_sw      (use_sw),
    .hold        (hold),
    .digital_sel (digital_sel),
    .nibble      (nibble),
    .digit_idx   (digit_idx),
    .frame_done  (frame_done),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  // One full frame sampled on falling edges: j=0..63 are the 8 slots, j=64 is LOAD.
  // act is applied right after the sample at j==act_j.
  task automatic run_frame(input logic [31:0] w, input int act_j, input int act);
    int s;
    int o;
    logic [7:0] exp_sel;
    logic [3:0] exp_nib;
    for (int j = 0; j < FRAME_CYC; j++) begin
      @(negedge clk);
      if (j == FRAME_CYC - 1) begin
        check("load_sel",   32'(digital_sel), 32'hFF);
        check("load_nib",   32'(nibble),      32'(w[31:28]));
        check("load_idx",   32'(digit_idx),   32'd7);
        check("load_done",  32'(frame_done),  32'd0);
        check("load_state", 32'(dbg_state),   32'(LOAD));
      end else begin
        s = j / SCAN_DIV;
        o = j % SCAN_DIV;
        exp_sel = (o < SHOW_CYC) ? ~(8'd1 << s) : 8'hFF;
        exp_nib = w[4*s +: 4];
        check("sel",  32'(digital_sel), 32'(exp_sel));
        check("nib",  32'(nibble),      32'(exp_nib));
        check("idx",  32'(digit_idx),   32'(s));
        check("done", 32'(frame_done),  32'(j == FRAME_CYC - 2));
      end
      check("excl", 32'($countones(~digital_sel) <= 1), 32'd1);
      if (j == act_j) begin
        case (act)
          1: use_sw = 1'b1;
          2: begin hold = 1'b1; src_cpu = 32'h0000_0000; end
          3: hold = 1'b0;
          4: use_sw = 1'b0;
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    nReset  = 1'b0;
    src_cpu = 32'h1907_1110;
    src_sw  = 32'hDEAD_BEEF;
    use_sw  = 1'b0;
    hold    = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_sel",  32'(digital_sel), 32'hFF);
    check("rst_nib",  32'(nibble),      32'h0);
    check("rst_idx",  32'(digit_idx),   32'h0);
    check("rst_done", 32'(frame_done),  32'h0);
    nReset = 1'b1;

    run_frame(32'h1907_1110, -1, 0);  // plain CPU frame
    run_frame(32'h1907_1110, 26, 1);  // use_sw raised during digit 3
    run_frame(32'hDEAD_BEEF, 10, 4);  // switch word; back to CPU for next LOAD
    run_frame(32'h1907_1110, 40, 2);  // freeze and zero the CPU word mid-frame
    run_frame(32'h1907_1110, -1, 0);  // held
    run_frame(32'h1907_1110, 20, 3);  // still held; release hold mid-frame
    run_frame(32'h0000_0000, -1, 0);  // zeros after hold released

    // Asynchronous reset in the middle of a SHOW slot.
    repeat (2) @(negedge clk);
    check("pre_rst_sel", 32'(digital_sel), 32'hFE);
    #2;
    nReset = 1'b0;
    #1;
    check("async_sel",  32'(digital_sel), 32'hFF);
    check("async_nib",  32'(nibble),      32'h0);
    check("async_idx",  32'(digit_idx),   32'h0);
    check("async_done", 32'(frame_done),  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
